digit_entry_ctrl: RTL and testbench

DIGIT_ENTRY_CTRL -- requirements
Module: digit_entry_ctrl

---
 rtl/digit_entry_ctrl.sv | 100 ++++++++++
 tb/tb_digit_entry_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry_ctrl.sv
// Four-digit entry sequencer: captures sw on a debounced button press into slot idx and pulses load/done.
// All outputs registered; press-to-load and final-release-to-done are both one cycle.
module digit_entry_ctrl #(
    parameter int RELEASE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic [3:0] sw,
    input  logic       clr,
    output logic [3:0] D_out,
    output logic [3:0] load,
    output logic [1:0] idx,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REL = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    // The release completes on the edge that samples the last required high,
    // so the registered count only ever needs to reach RELEASE_CYCLES-1.
    localparam logic [3:0] REL_LAST = 4'(RELEASE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] d_nxt;
    logic [3:0] load_nxt;
    logic [1:0] idx_nxt;
    logic       done_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        d_nxt     = D_out;
        load_nxt  = 4'b0000;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        if (clr) begin
            state_nxt = DRAIN;
            cnt_nxt   = 4'd0;
            d_nxt     = 4'd0;
            idx_nxt   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!btn_n) begin
                        d_nxt     = sw;
                        load_nxt  = 4'b0001 << idx;
                        cnt_nxt   = 4'd0;
                        state_nxt = WAIT_REL;
                    end
                end
                WAIT_REL, DRAIN: begin
                    if (!btn_n) begin
                        cnt_nxt = 4'd0;
                    end else if (cnt >= REL_LAST) begin
                        cnt_nxt   = 4'd0;
                        state_nxt = IDLE;
                        // A drain after clr returns to IDLE without touching the slot index.
                        if (state == WAIT_REL) begin
                            idx_nxt  = idx + 2'd1;
                            done_nxt = (idx == 2'd3);
                        end
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            D_out <= 4'd0;
            load  <= 4'b0000;
            idx   <= 2'd0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            D_out <= d_nxt;
            load  <= load_nxt;
            idx   <= idx_nxt;
            done  <= done_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Scoreboard bench for digit_entry_ctrl: a behavioural entry model queues expected load/done pulses,
// a monitor checks them plus idx/busy/D_out every cycle.
module tb_digit_entry_ctrl;

    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       rst, btn_n, clr;
    logic [3:0] sw;
    logic [3:0] D_out, load;
    logic [1:0] idx;
    logic       done, busy;

    digit_entry_ctrl #(.RELEASE_CYCLES(RC)) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .sw    (sw),
        .clr   (clr),
        .D_out (D_out),
        .load  (load),
        .idx   (idx),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         is_done;
        logic [3:0] ld;
        logic [3:0] d;
    } ev_t;

    ev_t q[$];

    int nvec = 0;
    int errs = 0;
    int edge_no = 0;
    bit chk_en = 0;

    // Reference model: mode 0 = waiting for press, 1 = digit held, 2 = draining after abort.
    int         m_mode = 0;
    int         m_run  = 0;
    int         m_slot = 0;
    logic [3:0] m_d    = 4'd0;

    task automatic push_ev(input bit is_done, input logic [3:0] ld, input logic [3:0] d);
        ev_t e;
        e.cyc = edge_no + 1;
        e.is_done = is_done;
        e.ld = ld;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic model_edge(input logic r, input logic c, input logic b, input logic [3:0] s);
        if (!r) begin
            m_mode = 0; m_run = 0; m_slot = 0; m_d = 4'd0;
        end else if (c) begin
            m_mode = 2; m_run = 0; m_slot = 0; m_d = 4'd0;
        end else if (m_mode == 0) begin
            if (!b) begin
                m_d = s;
                push_ev(1'b0, 4'(1 << m_slot), s);
                m_mode = 1;
                m_run = 0;
            end
        end else if (!b) begin
            m_run = 0;
        end else begin
            m_run = m_run + 1;
            if (m_run == RC) begin
                m_run = 0;
                if (m_mode == 1) begin
                    if (m_slot == 3) begin
                        m_slot = 0;
                        push_ev(1'b1, 4'd0, m_d);
                    end else begin
                        m_slot = m_slot + 1;
                    end
                end
                m_mode = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at edge %0d: got %h, want %h", nm, edge_no, act, exp);
        end
    endtask

    always @(posedge clk) begin
        ev_t e;
        edge_no++;
        #2;
        if (chk_en) begin
            chk("idx", {2'b00, idx}, 4'(m_slot));
            chk("busy", {3'b000, busy}, {3'b000, (m_mode != 0)});
            chk("D_out", D_out, m_d);
            if (load !== 4'b0000 || done !== 1'b0) begin
                if (q.size() == 0) begin
                    nvec++; errs++;
                    $display("FAIL unexpected_pulse at edge %0d: load=%b done=%b, want none", edge_no, load, done);
                end else begin
                    e = q.pop_front();
                    chk("pulse_cycle", 4'(e.cyc - edge_no), 4'd0);
                    chk("load", load, e.ld);
                    chk("done", {3'b000, done}, {3'b000, e.is_done});
                    if (!e.is_done) chk("D_out_at_load", D_out, e.d);
                end
            end else if (q.size() > 0 && q[0].cyc <= edge_no) begin
                e = q.pop_front();
                nvec++; errs++;
                $display("FAIL missing_pulse at edge %0d: load=%b done=%b, want load=%b done=%b",
                         edge_no, load, done, e.ld, e.is_done);
            end
        end
    end

    task automatic step(input logic r, input logic c, input logic b, input logic [3:0] s);
        @(negedge clk);
        rst = r; clr = c; btn_n = b; sw = s;
        model_edge(r, c, b, s);
    endtask

    task automatic press(input logic [3:0] s, input int hold);
        for (int i = 0; i < hold; i++) step(1'b1, 1'b0, 1'b0, s);
    endtask

    task automatic release_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
    endtask

    initial begin
        logic [3:0] digits [4];
        logic       b;
        digits[0] = 4'd3; digits[1] = 4'd7; digits[2] = 4'd0; digits[3] = 4'd9;

        rst = 1'b0; clr = 1'b0; btn_n = 1'b1; sw = 4'd0;
        model_edge(1'b0, 1'b0, 1'b1, 4'd0);
        chk_en = 1;
        step(1'b0, 1'b0, 1'b1, 4'd5);
        release_n(2);

        // Full four-digit entry.
        for (int k = 0; k < 4; k++) begin
            press(digits[k], 3);
            release_n(4);
        end
        release_n(2);

        // Bounce during release.
        press(4'd6, 2);
        step(1'b1, 1'b0, 1'b1, 4'd1);
        step(1'b1, 1'b0, 1'b1, 4'd1);
        step(1'b1, 1'b0, 1'b0, 4'd2);
        release_n(4);
        release_n(1);

        // Long hold with sw changing every cycle.
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
        release_n(5);

        // Abort mid-entry while the button is held.
        step(1'b0, 1'b0, 1'b1, 4'd0);
        press(4'd1, 2); release_n(4);
        press(4'd2, 2); release_n(4);
        press(4'd4, 1);
        step(1'b1, 1'b1, 1'b0, 4'd8);
        press(4'd8, 3);
        release_n(4);
        press(4'd12, 1); release_n(4);

        // Reset while the fourth digit is held.
        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin press(4'(k + 2), 2); release_n(4); end
        press(4'd15, 2);
        step(1'b0, 1'b0, 1'b0, 4'd15);
        release_n(6);
        press(4'd10, 1); release_n(4);

        // clr on the same edge that completes the final release, then rst with clr.
        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin press(4'(k + 5), 2); release_n(4); end
        press(4'd11, 2);
        release_n(3);
        step(1'b1, 1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 1'b1, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        release_n(2);

        // Random traffic.
        b = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 79) == 0), b,
                 4'($urandom_range(0, 15)));
        end

        release_n(8);
        @(posedge clk);
        #4;
        chk("queue_drained", 4'(q.size()), 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
